data_ram_arbiter: RTL and testbench
===================================

Name: data_ram_arbiter

Overview:
- Two-port arbiter and access sequencer for the byte-organised data memory.
- Two requesters share one memory: port 0 is the CPU load/store unit, port 1 is the loader/debug port. Each issues 32-bit word reads and writes.
- The block grants one requester at a time with round-robin fairness. It performs each word access as four big-endian byte beats on an 8-bit memory port and returns read data with a one-cycle done pulse.

Parameters:
- ADDR_W, default 8: byte-address width on the memory side (256-byte memory).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 request pending.
- req0_rw  in  1  port 0 direction: 1 = write, 0 = read.
- req0_addr  in  32  port 0 byte address of the MSB byte.
- req0_wdata  in  32  port 0 write word.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_done  out  1  port 0 access complete; one-cycle pulse.
- req0_rdata  out  32  port 0 read word; valid while req0_done is high.
- req1_valid, req1_rw, req1_addr, req1_wdata, req1_ready, req1_done, req1_rdata: same as port 0, for port 1.
- busy  out  1  an access is in flight (state is not IDLE).
- mem_addr  out  ADDR_W  byte address to memory.
- mem_we  out  1  byte write strobe; memory writes on the CLK edge while high.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  byte read combinationally from mem_addr.

Behaviour:
- Reset (asynchronous, while Reset = 0):
  - State = IDLE; last_grant = 1, so port 0 wins the first tie.
  - All outputs are 0: ready, done, rdata, busy, mem_addr, mem_we, mem_wdata.
  - Reset mid-access aborts it immediately: mem_we drops at once, no done pulse is issued, and the partially written bytes remain in memory.
- States: IDLE -> BEAT (4 cycles, beat counter 0..3) -> DONE (1 cycle) -> IDLE.
- IDLE, arbitration:
  - If exactly one reqN_valid is high, grant that port.
  - If both are high, grant the port not equal to last_grant.
  - The grant raises reqN_ready combinationally in that cycle, only in IDLE. On the edge, the block latches addr, rw, wdata and the granted port id, updates last_grant, and moves to BEAT with beat = 0.
  - reqN_valid low on the other port has no effect. The loser keeps valid high and is granted at the next IDLE.
- BEAT k (k = 0..3):
  - mem_addr = (latched_addr + k) mod 2^ADDR_W. Upper address bits above ADDR_W are ignored, and the address wraps 255 -> 0 at the default width.
  - Write: mem_we = 1, mem_wdata = wdata[31-8k -: 8].
  - Read: mem_we = 0, mem_wdata = 0, and mem_rdata is captured into rdata[31-8k -: 8] at the end of the beat.
  - After k = 3, move to DONE.
- DONE:
  - The granted port's done pulses high for one cycle.
  - On a read, its rdata holds the assembled word. rdata holds its value until that port's next read completes.
  - On a write, rdata is unchanged.
  - Move to IDLE. No request is accepted in DONE.
- Latency: ready at cycle T, beats at T+1..T+4, done at T+5. The earliest next grant is at T+6, giving a throughput of 1 word per 6 cycles.
- busy = 1 in BEAT and DONE.
- Request inputs are ignored outside IDLE. Changing reqN_* after acceptance does not affect the access in flight.
- A request with no valid asserted never produces ready or done.

Test Plan:
- Reset, then port 0 write, addr 0x10, wdata 0xDEADBEEF -> req0_ready at T. The memory sees bytes 0xDE, 0xAD, 0xBE, 0xEF at 0x10..0x13 with mem_we = 1 over T+1..T+4. req0_done at T+5; busy low at T+6.
- Port 1 read, addr 0x10, after the above -> req1_done at T+5 with req1_rdata = 0xDEADBEEF. req0_done stays 0 throughout.
- Both valid in the same cycle straight out of reset -> port 0 granted first, then port 1 at the next IDLE. Hold both high for 4 more accesses -> grants alternate 0,1,0,1.
- Write addr 0xFE, wdata 0x11223344 -> bytes land at 0xFE=0x11, 0xFF=0x22, 0x00=0x33, 0x01=0x44. A read of 0xFE returns 0x11223344.
- Write 0xAABBCCDD to 0x20; deassert Reset during beat 2 -> mem_we drops to 0 immediately and no done pulse occurs. After release, a read of 0x20 returns 0xAABB followed by the previous contents of 0x22..0x23.
- Change req0_addr and req0_wdata to junk during BEAT -> the access completes to the originally latched address and data.

Source files
------------

// File: rtl/data_ram_arbiter_if.sv
// Bus bundle for the data RAM arbiter: two word requesters, the byte-wide memory port
// and the FSM debug view. The arbiter uses the slave modport, the requester/memory side uses master.
interface data_ram_arbiter_if #(
  parameter int ADDR_W = 8
);
  // Handshake: a request is accepted on a rising CLK edge only when reqN_valid and reqN_ready
  // are both high. reqN_ready is combinational and can only be high while the arbiter is idle.
  // reqN_done pulses for one cycle when that port's access has finished.
  logic              req0_valid;
  logic              req0_rw;
  logic [31:0]       req0_addr;
  logic [31:0]       req0_wdata;
  logic              req0_ready;
  logic              req0_done;
  logic [31:0]       req0_rdata;

  logic              req1_valid;
  logic              req1_rw;
  logic [31:0]       req1_addr;
  logic [31:0]       req1_wdata;
  logic              req1_ready;
  logic              req1_done;
  logic [31:0]       req1_rdata;

  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic [1:0]        dbg_state;

  modport slave (
    input  req0_valid, req0_rw, req0_addr, req0_wdata,
    output req0_ready, req0_done, req0_rdata,
    input  req1_valid, req1_rw, req1_addr, req1_wdata,
    output req1_ready, req1_done, req1_rdata,
    output busy, mem_addr, mem_we, mem_wdata, dbg_state,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_rw, req0_addr, req0_wdata,
    input  req0_ready, req0_done, req0_rdata,
    output req1_valid, req1_rw, req1_addr, req1_wdata,
    input  req1_ready, req1_done, req1_rdata,
    input  busy, mem_addr, mem_we, mem_wdata, dbg_state,
    output mem_rdata
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter for two 32-bit requesters sharing a byte-wide data RAM.
// Each word access is sequenced as four big-endian byte beats, followed by a one-cycle done pulse.
module data_ram_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic               CLK,
  input  logic               Reset,
  data_ram_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_beat;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic              r_port;
  logic              r_last_grant;
  logic [31:0]       r_wdata;
  logic [31:0]       r_asm;
  logic [31:0]       r_rdata0;
  logic [31:0]       r_rdata1;

  logic              w_grant_vld;
  logic              w_grant_port;
  logic              w_accept;
  logic              w_last_beat;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_asm_next;
  logic              w_unused;

  // Only the low ADDR_W address bits reach the memory.
  assign w_unused = ^{bus.req0_addr[31:ADDR_W], bus.req1_addr[31:ADDR_W]};

  // When both ports request, the port that was not granted last time wins.
  always_comb begin
    w_grant_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) w_grant_port = ~r_last_grant;
    else                                  w_grant_port = bus.req1_valid;
  end

  // Reset also gates acceptance, so ready stays low while Reset is held.
  assign w_accept    = (r_state == S_IDLE) && w_grant_vld && Reset;
  assign w_last_beat = (r_beat == 2'd3);

  always_comb begin
    w_wbyte    = 8'h00;
    w_asm_next = r_asm;
    case (r_beat)
      2'd0: begin w_wbyte = r_wdata[31:24]; w_asm_next = {bus.mem_rdata, r_asm[23:0]}; end
      2'd1: begin w_wbyte = r_wdata[23:16]; w_asm_next = {r_asm[31:24], bus.mem_rdata, r_asm[15:0]}; end
      2'd2: begin w_wbyte = r_wdata[15:8];  w_asm_next = {r_asm[31:16], bus.mem_rdata, r_asm[7:0]}; end
      default: begin w_wbyte = r_wdata[7:0]; w_asm_next = {r_asm[31:8], bus.mem_rdata}; end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BEAT;
      S_BEAT:  if (w_last_beat) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.req0_done  = 1'b0;
    bus.req1_done  = 1'b0;
    bus.busy       = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = 8'h00;
    case (r_state)
      S_IDLE: begin
        bus.req0_ready = w_accept & ~w_grant_port;
        bus.req1_ready = w_accept &  w_grant_port;
      end
      S_BEAT: begin
        bus.busy      = 1'b1;
        bus.mem_addr  = r_addr + ADDR_W'(r_beat);
        bus.mem_we    = r_rw;
        bus.mem_wdata = r_rw ? w_wbyte : 8'h00;
      end
      S_DONE: begin
        bus.busy      = 1'b1;
        bus.req0_done = ~r_port;
        bus.req1_done =  r_port;
      end
      default: ;
    endcase
  end

  assign bus.dbg_state  = r_state;
  assign bus.req0_rdata = r_rdata0;
  assign bus.req1_rdata = r_rdata1;

  // The request is latched at acceptance, so later changes on the request inputs are ignored.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_beat       <= 2'd0;
      r_addr       <= '0;
      r_rw         <= 1'b0;
      r_port       <= 1'b0;
      r_last_grant <= 1'b1;
      r_wdata      <= 32'h0;
      r_asm        <= 32'h0;
      r_rdata0     <= 32'h0;
      r_rdata1     <= 32'h0;
    end else if (w_accept) begin
      r_beat       <= 2'd0;
      r_port       <= w_grant_port;
      r_last_grant <= w_grant_port;
      r_rw         <= w_grant_port ? bus.req1_rw : bus.req0_rw;
      r_addr       <= w_grant_port ? bus.req1_addr[ADDR_W-1:0] : bus.req0_addr[ADDR_W-1:0];
      r_wdata      <= w_grant_port ? bus.req1_wdata : bus.req0_wdata;
    end else if (r_state == S_BEAT) begin
      r_beat <= r_beat + 2'd1;
      if (!r_rw) begin
        r_asm <= w_asm_next;
        // Publish the whole word on the last beat so rdata is valid throughout DONE.
        if (w_last_beat) begin
          if (r_port) r_rdata1 <= w_asm_next;
          else        r_rdata0 <= w_asm_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed vector table, hand-written reset/arbitration sequences,
// and randomized traffic checked against a word-level memory and round-robin model.
module tb_data_ram_arbiter;
  logic clk;
  logic rst_n;
  data_ram_arbiter_if #(.ADDR_W(8)) bus();

  data_ram_arbiter #(.ADDR_W(8)) dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // byte memory attached to the DUT
  logic [7:0] mem [256];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  // reference model state
  logic [7:0]  ref_mem [256];
  logic        m_last;
  logic [31:0] m_rdata [2];
  logic [31:0] exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic v0, input logic v1);
    if (v0 && v1) return m_last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic drive_req(input logic v0, input logic v1, input logic rw0, input logic rw1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] w0, input logic [31:0] w1);
    bus.req0_valid = v0; bus.req0_rw = rw0; bus.req0_addr = a0; bus.req0_wdata = w0;
    bus.req1_valid = v1; bus.req1_rw = rw1; bus.req1_addr = a1; bus.req1_wdata = w1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_req(1'b1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h8, 32'h12345678, 32'h0);
    #1;
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    check("rst_done0", bus.req0_done, 0);
    check("rst_done1", bus.req1_done, 0);
    check("rst_rdata0", bus.req0_rdata, 0);
    check("rst_rdata1", bus.req1_rdata, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    m_last = 1'b1;
    m_rdata[0] = 32'h0;
    m_rdata[1] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // One arbitration slot: present a request pair, follow the granted access through to done.
  task automatic run_access(input logic v0, input logic v1, input logic rw0, input logic rw1,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] w0, input logic [31:0] w1,
                            output int gp, output logic [31:0] rd);
    int ep;
    logic rw;
    logic [31:0] a, w, exp_rd;
    logic [7:0] ba;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    drive_req(v0, v1, rw0, rw1, a0, a1, w0, w1);
    #1;
    ep = model_grant(v0, v1);
    gp = bus.req0_ready ? 0 : (bus.req1_ready ? 1 : -1);
    rd = 32'h0;
    check("grant_ready0", bus.req0_ready, ep == 0);
    check("grant_ready1", bus.req1_ready, ep == 1);
    if (ep < 0) begin
      repeat (6) begin
        @(negedge clk); #1;
        check("idle_ready", {bus.req0_ready, bus.req1_ready}, 0);
        check("idle_done", {bus.req0_done, bus.req1_done}, 0);
        check("idle_busy_hold", bus.busy, 0);
      end
      return;
    end
    m_last = ep[0];
    rw = ep ? rw1 : rw0;
    a  = ep ? a1 : a0;
    w  = ep ? w1 : w0;
    exp_rd = 32'h0;
    for (int k = 0; k < 4; k++) begin
      ba = a[7:0] + 8'(k);
      if (rw) begin
        exp_q.push_back(32'(w[31-8*k -: 8]));
        ref_mem[ba] = w[31-8*k -: 8];
      end else begin
        exp_rd = {exp_rd[23:0], ref_mem[ba]};
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (ep == 0) begin bus.req0_addr = $urandom; bus.req0_wdata = $urandom; bus.req0_rw = ~rw; end
        else         begin bus.req1_addr = $urandom; bus.req1_wdata = $urandom; bus.req1_rw = ~rw; end
      end
      #1;
      ba = a[7:0] + 8'(k);
      check("beat_mem_addr", bus.mem_addr, ba);
      check("beat_mem_we", bus.mem_we, rw);
      check("beat_mem_wdata", bus.mem_wdata, rw ? exp_q.pop_front() : 32'h0);
      check("beat_busy", bus.busy, 1);
      check("beat_ready", {bus.req0_ready, bus.req1_ready}, 0);
      check("beat_done", {bus.req0_done, bus.req1_done}, 0);
    end
    @(negedge clk); #1;
    check("done0", bus.req0_done, ep == 0);
    check("done1", bus.req1_done, ep == 1);
    check("done_busy", bus.busy, 1);
    check("done_ready", {bus.req0_ready, bus.req1_ready}, 0);
    if (!rw) m_rdata[ep] = exp_rd;
    check("rdata0", bus.req0_rdata, m_rdata[0]);
    check("rdata1", bus.req1_rdata, m_rdata[1]);
    rd = ep ? bus.req1_rdata : bus.req0_rdata;
  endtask

  typedef struct {
    logic        v0, v1, rw0, rw1;
    logic [31:0] a0, a1, w0, w1;
    int          exp_port;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int gp;
    logic [31:0] rd;
    int arb_exp [5];

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h10,       32'h0,  32'hDEADBEEF, 32'h0, 0,  1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h10, 32'h0,        32'h0, 1,  1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hFE,       32'h10, 32'h11223344, 32'h0, 0,  1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h13,       32'hFE, 32'h0,        32'h0, 1,  1'b1, 32'h11223344};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hABCD0012, 32'h0,  32'h0,        32'h0, 0,  1'b1, 32'hBEEF0000};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h40,       32'h41, 32'h55,       32'h66, -1, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,  32'h0,        32'h0, 1,  1'b1, 32'h33440000};
    arb_exp = '{0, 1, 0, 1, 0};

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst_n = 1'b1;
    m_last = 1'b1;
    m_rdata[0] = 32'h0;
    m_rdata[1] = 32'h0;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    do_reset();

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      run_access(tbl[i].v0, tbl[i].v1, tbl[i].rw0, tbl[i].rw1,
                 tbl[i].a0, tbl[i].a1, tbl[i].w0, tbl[i].w1, gp, rd);
      check($sformatf("tbl%0d_port", i), gp, tbl[i].exp_port);
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
    end

    // both ports valid straight out of reset: grants alternate starting with port 0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_access(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hFE, 32'h0, 32'h0, gp, rd);
      check($sformatf("arb%0d_port", i), gp, arb_exp[i]);
    end

    // reset during beat 2 of a write leaves the first two bytes behind
    run_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h01020304, 32'h0, gp, rd);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'hAABBCCDD, 32'h0);
    #1;
    check("rw_ready0", bus.req0_ready, model_grant(1'b1, 1'b0) == 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("rw_beat2_we", bus.mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("rw_abort_we", bus.mem_we, 0);
    check("rw_abort_busy", bus.busy, 0);
    check("rw_abort_done0", bus.req0_done, 0);
    ref_mem[8'h20] = 8'hAA;
    ref_mem[8'h21] = 8'hBB;
    m_last = 1'b1;
    m_rdata[0] = 32'h0;
    m_rdata[1] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("rw_no_done", {bus.req0_done, bus.req1_done}, 0);
    end
    run_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 32'h0, 32'h0, gp, rd);
    check("rw_partial_rdata", rd, 32'hAABB0304);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, $urandom, $urandom, gp, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
